// File: rtl/uart_pkg.sv
// Shared UART constants and the receiver state encoding.
// Imported by both the receive datapath and the FIFO stage.
package uart_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_RXFIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    READ  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_edge_sync.sv
// Three-flop synchronizer with a one-cycle rising-edge pulse; pulse two edges after d is first sampled high.
// Flops reset to 1 so a flag already high when reset releases is not seen as a new edge.
module uart_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;

endmodule

// File: rtl/uart_rx_fifo.sv
// Captures each received byte into a show-ahead FIFO; byte visible three edges after done is first sampled.
// Consumer stalls fill the FIFO; a push into a full FIFO with no pop is dropped and counted.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = UART_RXFIFO_DEPTH,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_done_in,
  input  logic [DATA_W-1:0] rx_data_in,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [AW:0]       level,
  output logic              full,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic [7:0]        drop_cnt
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic              push;
  logic              pop;
  logic              wr_en;
  logic              drop;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  uart_edge_sync u_done_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (rx_done_in),
    .pulse (push)
  );

  assign m_valid = (level != '0);
  assign full    = (level == FULL_LVL);
  assign m_data  = mem[rd_ptr];
  assign pop     = m_valid & m_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr_en   = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= rx_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // A drop in the same cycle as a clear wins, leaving a count of one.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (ovf_clr) begin
        drop_cnt <= 8'd1;
      end else if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end else if (ovf_clr) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end
  end

endmodule
